// File: rtl/chien_consts_pkg.sv
// Shared constants and types for the RS(544,522) Chien / error-position path.
//   N       : GF(2^10) field order minus one
//   n       : codeword length; Chien positions >= n lie outside the codeword
//   K       : message length
//   PW      : width of a codeword position index
//   pos_t   : codeword position index type
//   errpos_state_e : error-position collector FSM states
package chien_consts_pkg;

    localparam int unsigned N  = 1023;
    localparam int unsigned n  = 544;
    localparam int unsigned K  = 522;
    localparam int unsigned PW = $clog2(N);

    typedef logic [PW-1:0] pos_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        DRAIN
    } errpos_state_e;

endpackage

// File: rtl/chien_errpos_collector_compact.sv
// errpos_compact_p32: combinational lane compactor for one Chien cycle.
// Qualifies each lane hit by its position being inside the codeword, then
// gives every qualified lane its write slot (number of qualified lanes
// below it) and the total qualified hit count for the cycle.
//   hit_mask_i : per-lane root hit from chien_search
//   pos_bus_i  : per-lane codeword position
//   valid_o    : per-lane qualified hit
//   slot_o     : per-lane offset within this cycle's compacted group
//   hit_cnt_o  : number of qualified hits this cycle
module errpos_compact_p32
    import chien_consts_pkg::*;
#(
    parameter int unsigned P  = 32,
    parameter int unsigned SW = $clog2(P + 1)
) (
    input  logic [P-1:0]          hit_mask_i,
    input  logic [P-1:0][PW-1:0]  pos_bus_i,
    output logic [P-1:0]          valid_o,
    output logic [P-1:0][SW-1:0]  slot_o,
    output logic [SW-1:0]         hit_cnt_o
);

    logic [SW-1:0] run;

    // Running prefix popcount: lane k's slot counts qualified lanes 0..k-1,
    // which keeps lane 0 first in the compacted list.
    always_comb begin
        run     = '0;
        valid_o = '0;
        slot_o  = '0;
        for (int unsigned k = 0; k < P; k++) begin
            valid_o[k] = hit_mask_i[k] && (32'(pos_bus_i[k]) < n);
            slot_o[k]  = run;
            run        = run + SW'(valid_o[k]);
        end
        hit_cnt_o = run;
    end

endmodule

// File: rtl/chien_errpos_collector.sv
// chien_errpos_collector: compacts Chien hit lanes into an ordered list of
// up to T error positions, checks the count against the Lambda degree and
// streams the positions to the correction stage.
//   clk_i / rst_ni    : clock, synchronous active-low reset
//   start_i           : frame start, latches sigma_deg_i
//   sigma_deg_i       : degree of Lambda (0..T)
//   done_i            : last Chien hit cycle of the frame
//   hit_mask_i        : per-lane root hit
//   pos_bus_i         : per-lane codeword position
//   busy_o            : frame in progress (start accepted until drained/reported)
//   pos_valid_o / pos_ready_i / pos_o / pos_last_o : position stream
//   err_cnt_o         : number of collected positions
//   fail_o            : decode failure, qualified by verdict_valid_o
//   verdict_valid_o   : one-cycle verdict strobe
module chien_errpos_collector
    import chien_consts_pkg::*;
#(
    parameter int unsigned W = 10,
    parameter int unsigned T = 11,
    parameter int unsigned P = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [3:0]           sigma_deg_i,
    input  logic                 done_i,
    input  logic [P-1:0]         hit_mask_i,
    input  logic [P-1:0][W-1:0]  pos_bus_i,
    output logic                 busy_o,
    output logic                 pos_valid_o,
    input  logic                 pos_ready_i,
    output logic [W-1:0]         pos_o,
    output logic                 pos_last_o,
    output logic [3:0]           err_cnt_o,
    output logic                 fail_o,
    output logic                 verdict_valid_o
);

    localparam int unsigned SW = $clog2(P + 1);
    localparam int unsigned AW = SW + 1;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = $clog2(T);

    errpos_state_e          state_q;
    logic [W-1:0]           list_q [T];
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          deg_q;
    logic [CW-1:0]          rd_q;
    logic                   ovf_q;

    logic [P-1:0]           lane_valid;
    logic [P-1:0][SW-1:0]   lane_slot;
    logic [SW-1:0]          lane_hits;

    logic [AW-1:0]          sum;
    logic [CW-1:0]          cnt_nxt;
    logic                   ovf_nxt;
    logic [CW-1:0]          rd_nxt;
    logic [P-1:0]           wr_en;
    logic [P-1:0][IW-1:0]   wr_idx;

    errpos_compact_p32 #(
        .P  (P),
        .SW (SW)
    ) u_compact (
        .hit_mask_i (hit_mask_i),
        .pos_bus_i  (pos_bus_i),
        .valid_o    (lane_valid),
        .slot_o     (lane_slot),
        .hit_cnt_o  (lane_hits)
    );

    // Saturating list fill; overflow is sticky for the whole frame.
    always_comb begin
        sum     = AW'(cnt_q) + AW'(lane_hits);
        ovf_nxt = ovf_q | (sum > AW'(T));
        cnt_nxt = (sum > AW'(T)) ? CW'(T) : CW'(sum);
        rd_nxt  = rd_q + 1'b1;
        wr_en   = '0;
        wr_idx  = '0;
        for (int unsigned k = 0; k < P; k++) begin
            wr_en[k]  = lane_valid[k] && ((AW'(cnt_q) + AW'(lane_slot[k])) < AW'(T));
            wr_idx[k] = IW'(AW'(cnt_q) + AW'(lane_slot[k]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            deg_q           <= '0;
            rd_q            <= '0;
            ovf_q           <= 1'b0;
            for (int unsigned i = 0; i < T; i++) list_q[i] <= '0;
            busy_o          <= 1'b0;
            pos_valid_o     <= 1'b0;
            pos_o           <= '0;
            pos_last_o      <= 1'b0;
            err_cnt_o       <= '0;
            fail_o          <= 1'b0;
            verdict_valid_o <= 1'b0;
        end else begin
            verdict_valid_o <= 1'b0;
            fail_o          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        deg_q     <= sigma_deg_i;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        err_cnt_o <= '0;
                        busy_o    <= 1'b1;
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int unsigned k = 0; k < P; k++) begin
                        if (wr_en[k]) list_q[wr_idx[k]] <= pos_bus_i[k];
                    end
                    cnt_q <= cnt_nxt;
                    ovf_q <= ovf_nxt;
                    // Verdict is registered from the post-update count at the
                    // done edge, so the strobe lines up with the CHECK cycle.
                    if (done_i) begin
                        verdict_valid_o <= 1'b1;
                        fail_o          <= ovf_nxt | (cnt_nxt != deg_q);
                        err_cnt_o       <= cnt_nxt;
                        state_q         <= CHECK;
                    end
                end
                CHECK: begin
                    rd_q <= '0;
                    // fail_o still holds this frame's verdict during CHECK.
                    if (fail_o || (cnt_q == '0)) begin
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        pos_valid_o <= 1'b1;
                        pos_o       <= list_q[0];
                        pos_last_o  <= (cnt_q == CW'(1));
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pos_ready_i) begin
                        if (pos_last_o) begin
                            pos_valid_o <= 1'b0;
                            pos_last_o  <= 1'b0;
                            busy_o      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            rd_q       <= rd_nxt;
                            pos_o      <= list_q[IW'(rd_nxt)];
                            pos_last_o <= (rd_nxt == (cnt_q - 1'b1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chien_errpos_collector.sv
`timescale 1ns/1ps
module tb_chien_errpos_collector;

    localparam int P   = 32;
    localparam int T   = 11;
    localparam int NCW = 544;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [3:0]        sigma_deg_i;
    logic              done_i;
    logic [P-1:0]      hit_mask_i;
    logic [P-1:0][9:0] pos_bus_i;
    logic              busy_o;
    logic              pos_valid_o;
    logic              pos_ready_i;
    logic [9:0]        pos_o;
    logic              pos_last_o;
    logic [3:0]        err_cnt_o;
    logic              fail_o;
    logic              verdict_valid_o;

    always #5 clk = ~clk;

    chien_errpos_collector #(
        .W (10),
        .T (11),
        .P (32)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .sigma_deg_i     (sigma_deg_i),
        .done_i          (done_i),
        .hit_mask_i      (hit_mask_i),
        .pos_bus_i       (pos_bus_i),
        .busy_o          (busy_o),
        .pos_valid_o     (pos_valid_o),
        .pos_ready_i     (pos_ready_i),
        .pos_o           (pos_o),
        .pos_last_o      (pos_last_o),
        .err_cnt_o       (err_cnt_o),
        .fail_o          (fail_o),
        .verdict_valid_o (verdict_valid_o)
    );

    typedef struct packed {
        logic [P-1:0]      m;
        logic [P-1:0][9:0] p;
    } beat_t;

    typedef struct {
        int cnt;
        int fail;
        int cyc;
    } verdict_t;

    typedef struct {
        int pos;
        int last;
    } pos_exp_t;

    beat_t    frame_q[$];
    verdict_t exp_v[$];
    pos_exp_t exp_p[$];
    int       exp_first[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rdy_mode    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Ready generator: 0 always ready, 1 random, 2 held low, 3 alternating.
    initial begin
        bit tog;
        tog = 1'b0;
        pos_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pos_ready_i = 1'b1;
                1:       pos_ready_i = 1'($urandom_range(0, 1));
                2:       pos_ready_i = 1'b0;
                default: begin tog = ~tog; pos_ready_i = tog; end
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    initial begin
        verdict_t v;
        pos_exp_t e;
        bit       pv, pr, plast;
        int       ppos;
        pv = 0; pr = 0; plast = 0; ppos = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                pv = 0;
            end else begin
                if (verdict_valid_o) begin
                    if (exp_v.size() == 0) chk("verdict_unexpected", 1, 0);
                    else begin
                        v = exp_v.pop_front();
                        chk("verdict_fail", int'(fail_o), v.fail);
                        chk("verdict_cnt", int'(err_cnt_o), v.cnt);
                        chk("verdict_latency", cyc, v.cyc + 1);
                    end
                end
                if (pos_valid_o && !pv) begin
                    if (exp_first.size() == 0) chk("stream_unexpected", 1, 0);
                    else chk("first_beat_latency", cyc, exp_first.pop_front() + 2);
                end
                if (pv && !pr) begin
                    chk("hold_valid", int'(pos_valid_o), 1);
                    chk("hold_pos", int'(pos_o), ppos);
                    chk("hold_last", int'(pos_last_o), int'(plast));
                end
                if (pos_valid_o && pos_ready_i) begin
                    if (exp_p.size() == 0) chk("beat_unexpected", 1, 0);
                    else begin
                        e = exp_p.pop_front();
                        chk("beat_pos", int'(pos_o), e.pos);
                        chk("beat_last", int'(pos_last_o), e.last);
                    end
                end
                pv    = pos_valid_o;
                pr    = pos_ready_i;
                ppos  = int'(pos_o);
                plast = pos_last_o;
            end
        end
    end

    function automatic void beats(input int nb);
        beat_t z;
        z = '0;
        repeat (nb) frame_q.push_back(z);
    endfunction

    function automatic void hit(input int b, input int lane, input int pos);
        beat_t t;
        t = frame_q[b];
        t.m[lane] = 1'b1;
        t.p[lane] = 10'(pos);
        frame_q[b] = t;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", int'(busy_o), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference: every in-range hit in scan order, list capped at T entries.
    task automatic send_frame(input int deg, input bit wait_done, input bit chk_idle);
        int       total, c, f, streamed, last_i;
        int       pl[$];
        verdict_t v;
        pos_exp_t e;
        total = 0;
        foreach (frame_q[i])
            for (int k = 0; k < P; k++)
                if (frame_q[i].m[k] && int'(frame_q[i].p[k]) < NCW) begin
                    total++;
                    if (pl.size() < T) pl.push_back(int'(frame_q[i].p[k]));
                end
        c        = (total > T) ? T : total;
        f        = ((total > T) || (c != deg)) ? 1 : 0;
        streamed = (f == 0 && c > 0) ? 1 : 0;
        last_i   = frame_q.size() - 1;

        @(posedge clk);
        #1;
        start_i     = 1'b1;
        sigma_deg_i = 4'(deg);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("busy_rise", int'(busy_o), 1);
        foreach (frame_q[i]) begin
            hit_mask_i = frame_q[i].m;
            pos_bus_i  = frame_q[i].p;
            done_i     = (i == last_i);
            if (i == last_i) begin
                v.cnt = c; v.fail = f; v.cyc = cyc;
                exp_v.push_back(v);
                if (streamed != 0) begin
                    exp_first.push_back(cyc);
                    foreach (pl[j]) begin
                        e.pos  = pl[j];
                        e.last = (j == pl.size() - 1) ? 1 : 0;
                        exp_p.push_back(e);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        hit_mask_i = '0;
        pos_bus_i  = '0;
        done_i     = 1'b0;
        frame_q.delete();
        if (streamed == 0 && chk_idle) begin
            @(negedge clk);
            @(negedge clk);
            chk("busy_fall", int'(busy_o), 0);
        end
        if (wait_done) wait_idle();
    endtask

    task automatic rand_frame();
        int    nb, cnt, deg;
        beat_t t;
        nb  = $urandom_range(1, 4);
        cnt = 0;
        for (int b = 0; b < nb; b++) begin
            t = '0;
            for (int k = 0; k < P; k++)
                if ($urandom_range(0, 19) == 0) begin
                    t.m[k] = 1'b1;
                    t.p[k] = 10'($urandom_range(0, 1022));
                    if (int'(t.p[k]) < NCW) cnt++;
                end
            frame_q.push_back(t);
        end
        deg = ($urandom_range(0, 3) != 0 && cnt <= T) ? cnt : int'($urandom_range(0, T));
        send_frame(deg, 1'b1, 1'b0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        done_i      = 1'b0;
        sigma_deg_i = '0;
        hit_mask_i  = '0;
        pos_bus_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy_o, pos_valid_o, pos_o, pos_last_o,
                                  err_cnt_o, fail_o, verdict_valid_o}), 0);
        rst_ni = 1'b1;

        // single hit in the third collect cycle
        beats(3); hit(2, 5, 100);
        send_frame(1, 1'b1, 1'b0);
        // two hits in one cycle (lane order), then one more with done
        beats(2); hit(0, 31, 7); hit(0, 0, 40); hit(1, 2, 3);
        send_frame(3, 1'b1, 1'b0);
        // count mismatch
        beats(2); hit(0, 3, 200); hit(1, 9, 300);
        send_frame(4, 1'b1, 1'b1);
        // overflow: 12 valid hits over 3 cycles
        beats(3);
        for (int i = 0; i < 12; i++) hit(i / 4, (i % 4) * 8 + 1, 10 + i * 3);
        send_frame(11, 1'b1, 1'b1);
        // out-of-range hit dropped
        beats(1); hit(0, 0, 600); hit(0, 1, 5);
        send_frame(1, 1'b1, 1'b0);
        // no errors at all
        beats(1);
        send_frame(0, 1'b1, 1'b1);
        // alternating backpressure
        rdy_mode = 3;
        beats(1); hit(0, 4, 77); hit(0, 20, 500);
        send_frame(2, 1'b1, 1'b0);
        rdy_mode = 0;

        // reset while draining
        rdy_mode = 2;
        beats(1); hit(0, 1, 11); hit(0, 2, 22); hit(0, 3, 33);
        send_frame(3, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_before_reset", int'(pos_valid_o), 1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        rdy_mode = 0;
        exp_p.delete();
        chk("reset_mid_drain", int'({busy_o, pos_valid_o, pos_o, pos_last_o,
                                    err_cnt_o, fail_o, verdict_valid_o}), 0);
        beats(1); hit(0, 7, 123);
        send_frame(1, 1'b1, 1'b0);

        for (int f = 0; f < 40; f++) begin
            rdy_mode = int'($urandom_range(0, 1));
            rand_frame();
        end
        rdy_mode = 0;

        repeat (5) @(posedge clk);
        #1;
        chk("verdicts_outstanding", exp_v.size(), 0);
        chk("beats_outstanding", exp_p.size(), 0);
        chk("streams_outstanding", exp_first.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chien_errpos_collector.md
Name: chien_errpos_collector

Overview:
Sits directly downstream of chien_search in the RS(544,522) decoder. It consumes the per-cycle hit_mask/pos_bus lanes and compacts them into an ordered list of up to T error positions. It checks the hit count against the sigma degree from RiBM. It then streams the positions to the Forney/correction stage over a valid/ready handshake, with a last marker and a pass/fail verdict.

Parameters:
W, 10, GF(2^10) symbol width
T, 11, max correctable symbols (list depth)
P, 32, Chien lanes per cycle
N, 1023, field order minus one
n, 544, codeword length; positions >= n are discarded
PW, $clog2(N), position width (10)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse, same cycle as chien_search start_i; latches sigma_deg_i
sigma_deg_i  in  4  degree of Lambda from RiBM (0..T)
done_i  in  1  chien_search done_o pulse; marks the final hit cycle
hit_mask_i  in  P  chien_search hit_mask_o
pos_bus_i  in  P x PW  chien_search pos_bus_o (cw_idx per lane)
busy_o  out  1  high from accepted start until list fully drained or reported empty
pos_valid_o  out  1  streamed position valid
pos_ready_i  in  1  downstream ready
pos_o  out  PW  error position (cw_idx, 0..n-1)
pos_last_o  out  1  qualifies the final list entry
err_cnt_o  out  4  number of collected positions, held until next start
fail_o  out  1  decode failure verdict; valid while verdict_valid_o is high
verdict_valid_o  out  1  one-cycle pulse when count/degree check completes

Behaviour:
- Reset is synchronous and active-low. All outputs are 0 after reset. The FSM goes to IDLE, and the list, count, and overflow flag clear. Reset mid-operation aborts with no verdict pulse.
- FSM states: IDLE, COLLECT, CHECK, DRAIN.
- IDLE:
  - start_i latches sigma_deg_i and clears count and overflow; next state is COLLECT, and busy_o rises the next cycle.
  - start_i in any other state is ignored.
- COLLECT:
  - Each cycle, lanes with hit_mask_i[k]=1 and pos_bus_i[k] < n are appended in lane order (lane 0 first) at list[count].
  - Multiple hits per cycle are allowed, up to P.
  - If count+hits would exceed T, overflow is set sticky; entries beyond T are dropped and count saturates at T.
  - Hits are ignored outside COLLECT.
  - done_i: hits in the same cycle are included, then next state is CHECK.
- CHECK (1 cycle):
  - fail = overflow OR (count != deg).
  - verdict_valid_o pulses and err_cnt_o updates.
  - If fail, or count==0, next state is IDLE (nothing streamed). Otherwise next state is DRAIN.
- DRAIN:
  - pos_valid_o is high, pos_o = list[rd].
  - A transfer occurs when valid && ready; rd increments.
  - pos_last_o is high when rd == count-1.
  - pos_valid_o/pos_o stay stable while ready is low.
  - After the last transfer: IDLE, and busy_o falls the same edge.
- Latency: verdict 1 cycle after done_i. First pos_valid_o 2 cycles after done_i.
- Positions are emitted in Chien scan order, with no sorting or duplicate suppression (the chien stage guarantees unique positions).

Decomposition:
- chien_consts_pkg (existing) gains:
  - typedef errpos_state_e {IDLE, COLLECT, CHECK, DRAIN}
  - typedef pos_t = logic [PW-1:0]
  - localparam n = 544, K = 522, N = 1023
- One combinational sub-module, errpos_compact_p32: masks hits with pos < n, computes the lane prefix popcount and a per-lane write slot, and returns the hit count for the cycle.

Test Plan:
- Single hit: deg=1, one hit lane 5 pos=100 in cycle 3, done_i in cycle 3 -> verdict fail=0, cnt=1; one beat pos=100 with last=1.
- Multi-hit compaction: deg=3, hits lane 31 pos=7 and lane 0 pos=40 in one cycle, then lane 2 pos=3 with done -> stream 40, 7, 3, last on 3, fail=0.
- Count mismatch: deg=4, only 2 hits -> verdict fail=1, cnt=2, no pos_valid_o, busy_o low next cycle.
- Overflow: deg=11, 12 valid hits across cycles -> fail=1, cnt=11, nothing streamed.
- Out-of-range and no-error: a hit with pos=600 is dropped. With deg=0 and zero hits -> fail=0, cnt=0, no stream.
- Backpressure/reset: deg=2, pos_ready_i toggled 0,1,0,1 -> exactly 2 beats with stable data. Separately, rst_ni=0 mid-DRAIN -> all outputs 0 next cycle, and a new start after reset works.
